// File: rtl/io_conc_pkg.sv
// Shared types and helpers for the Hermes IO concentrator.
//   egr_state_e / ing_state_e : egress and ingress FSM states
//   pkt_pos_e                 : flit position inside a packet (tracker)
//   rr_next                   : round-robin winner search
package io_conc_pkg;

  localparam int unsigned HDR_ADDR_W = 16;
  localparam int unsigned SIZE_W     = 16;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned CH_IDX_W   = 3;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_HDR  = 2'd1,
    E_SIZE = 2'd2,
    E_PAY  = 2'd3
  } egr_state_e;

  typedef enum logic [1:0] {
    I_HDR  = 2'd0,
    I_SIZE = 2'd1,
    I_PAY  = 2'd2
  } ing_state_e;

  typedef enum logic [1:0] {
    P_HDR  = 2'd0,
    P_SIZE = 2'd1,
    P_PAY  = 2'd2
  } pkt_pos_e;

  // First requester after 'last', wrapping modulo n_ch; returns 'last' if none.
  function automatic logic [CH_IDX_W-1:0] rr_next(input logic [MAX_CH-1:0]   req,
                                                 input logic [CH_IDX_W-1:0] last,
                                                 input int unsigned         n_ch);
    int unsigned idx;
    logic        found;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = (32'(last) + i) % n_ch;
      if (!found && (i <= n_ch) && req[CH_IDX_W'(idx)]) begin
        rr_next = CH_IDX_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/hermes_pkt_tracker.sv
// Tracks the position of flits within a Hermes packet (header, size, payload).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   xfer          : a flit transfers this cycle
//   size          : low bits of the current flit (size field when at the size flit)
//   is_hdr        : current flit is a header
//   is_size       : current flit is the size flit
//   last_flit     : current flit ends the packet (size with S==0, or last payload)
module hermes_pkt_tracker
  import io_conc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              xfer,
  input  logic [SIZE_W-1:0] size,
  output logic              is_hdr,
  output logic              is_size,
  output logic              last_flit
);

  pkt_pos_e          pos_q, pos_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;

  // Position register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= P_HDR;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

  // Position decode and advance on each transfer
  always_comb begin
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    is_hdr    = (pos_q == P_HDR);
    is_size   = (pos_q == P_SIZE);
    last_flit = ((pos_q == P_SIZE) && (size == '0)) ||
                ((pos_q == P_PAY) && (cnt_q == SIZE_W'(1)));
    if (xfer) begin
      case (pos_q)
        P_HDR:   pos_d = P_SIZE;
        P_SIZE: begin
          cnt_d = size;
          pos_d = (size == '0) ? P_HDR : P_PAY;
        end
        P_PAY: begin
          cnt_d = cnt_q - SIZE_W'(1);
          if (cnt_q == SIZE_W'(1)) pos_d = P_HDR;
        end
        default: pos_d = P_HDR;
      endcase
    end
  end

endmodule

// File: rtl/hermes_io_concentrator.sv
// Concentrates N_CH peripheral channels onto one Hermes router port.
// Egress: packet-level round-robin, zero-latency pass-through once granted.
// Ingress: header address decode to a channel; unmatched packets are drained
// and counted.
// Ports:
//   clk_i, rst_ni                       : clock, async active-low reset
//   ch_rx_i/ch_data_i/ch_credit_o       : per-channel egress link
//   ch_tx_o/ch_data_o/ch_credit_i       : per-channel ingress link
//   noc_tx_o/noc_data_o/noc_credit_i    : link towards the router
//   noc_rx_i/noc_data_i/noc_credit_o    : link from the router
//   drop_cnt_o                          : saturating count of drained packets
module hermes_io_concentrator
  import io_conc_pkg::*;
#(
  parameter int unsigned                          N_CH      = 2,
  parameter int unsigned                          FLIT_SIZE = 32,
  parameter logic [N_CH-1:0][HDR_ADDR_W-1:0]      CH_ADDR   = {16'h0100, 16'h0000}
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_CH-1:0]                  ch_rx_i,
  output logic [N_CH-1:0]                  ch_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0]   ch_data_i,
  output logic [N_CH-1:0]                  ch_tx_o,
  input  logic [N_CH-1:0]                  ch_credit_i,
  output logic [N_CH-1:0][FLIT_SIZE-1:0]   ch_data_o,
  output logic                             noc_tx_o,
  input  logic                             noc_credit_i,
  output logic [FLIT_SIZE-1:0]             noc_data_o,
  input  logic                             noc_rx_i,
  output logic                             noc_credit_o,
  input  logic [FLIT_SIZE-1:0]             noc_data_i,
  output logic [15:0]                      drop_cnt_o
);

  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // ---------------- Egress ----------------
  egr_state_e    egr_q, egr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic          egr_xfer;
  logic          egr_is_hdr, egr_is_size, egr_last;

  // Egress state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      egr_q   <= E_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_CH - 1);
    end else begin
      egr_q   <= egr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Pass-through of the granted channel while a packet is in flight
  always_comb begin
    noc_tx_o    = 1'b0;
    noc_data_o  = '0;
    ch_credit_o = '0;
    if (egr_q != E_IDLE) begin
      noc_tx_o             = ch_rx_i[grant_q];
      noc_data_o           = ch_data_i[grant_q];
      ch_credit_o[grant_q] = noc_credit_i;
    end
  end

  assign egr_xfer = noc_tx_o && noc_credit_i;

  // Egress next state: arbitrate in idle, hold the lock until the last flit
  always_comb begin
    egr_d   = egr_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (egr_q)
      E_IDLE: begin
        if (|ch_rx_i) begin
          grant_d = GW'(rr_next(MAX_CH'(ch_rx_i), CH_IDX_W'(last_q), N_CH));
          egr_d   = E_HDR;
        end
      end
      E_HDR: begin
        if (egr_xfer && egr_is_hdr) egr_d = E_SIZE;
      end
      E_SIZE: begin
        if (egr_xfer && egr_is_size) begin
          if (egr_last) begin
            egr_d  = E_IDLE;
            last_d = grant_q;
          end else begin
            egr_d = E_PAY;
          end
        end
      end
      E_PAY: begin
        if (egr_xfer && egr_last) begin
          egr_d  = E_IDLE;
          last_d = grant_q;
        end
      end
      default: egr_d = E_IDLE;
    endcase
  end

  hermes_pkt_tracker u_egr_trk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .xfer      (egr_xfer),
    .size      (noc_data_o[SIZE_W-1:0]),
    .is_hdr    (egr_is_hdr),
    .is_size   (egr_is_size),
    .last_flit (egr_last)
  );

  // ---------------- Ingress ----------------
  ing_state_e    ing_q, ing_d;
  logic [GW-1:0] tgt_q, tgt_d;
  logic          hit_q, hit_d;
  logic [GW-1:0] dec_tgt, sel_tgt;
  logic          dec_hit, sel_hit;
  logic          ing_xfer;
  logic          ing_is_hdr, ing_is_size, ing_last;
  logic          run_q;
  logic [15:0]   drop_q;

  // Outputs stay quiet until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Header decode: lowest matching channel wins
  always_comb begin
    dec_hit = 1'b0;
    dec_tgt = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (CH_ADDR[i] == noc_data_i[HDR_ADDR_W-1:0]) begin
        dec_hit = 1'b1;
        dec_tgt = GW'(i);
      end
    end
  end

  // Route to the target channel, or drain when nobody owns the address
  always_comb begin
    ch_tx_o      = '0;
    noc_credit_o = 1'b0;
    sel_hit      = (ing_q == I_HDR) ? dec_hit : hit_q;
    sel_tgt      = (ing_q == I_HDR) ? dec_tgt : tgt_q;
    if (run_q) begin
      if (sel_hit) begin
        ch_tx_o[sel_tgt] = noc_rx_i;
        noc_credit_o     = ch_credit_i[sel_tgt];
      end else begin
        noc_credit_o = 1'b1;
      end
    end
  end

  assign ing_xfer  = noc_rx_i && noc_credit_o;
  assign ch_data_o = run_q ? {N_CH{noc_data_i}} : '0;

  // Ingress next state
  always_comb begin
    ing_d = ing_q;
    tgt_d = tgt_q;
    hit_d = hit_q;
    case (ing_q)
      I_HDR: begin
        if (ing_xfer && ing_is_hdr) begin
          tgt_d = dec_tgt;
          hit_d = dec_hit;
          ing_d = I_SIZE;
        end
      end
      I_SIZE: begin
        if (ing_xfer && ing_is_size) ing_d = ing_last ? I_HDR : I_PAY;
      end
      I_PAY: begin
        if (ing_xfer && ing_last) ing_d = I_HDR;
      end
      default: ing_d = I_HDR;
    endcase
  end

  // Ingress state register and drop counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ing_q  <= I_HDR;
      tgt_q  <= '0;
      hit_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ing_q <= ing_d;
      tgt_q <= tgt_d;
      hit_q <= hit_d;
      if (ing_xfer && ing_last && !hit_q && (ing_q != I_HDR) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_q;

  hermes_pkt_tracker u_ing_trk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .xfer      (ing_xfer),
    .size      (noc_data_i[SIZE_W-1:0]),
    .is_hdr    (ing_is_hdr),
    .is_size   (ing_is_size),
    .last_flit (ing_last)
  );

endmodule
